// File: rtl/btn_gesture_decoder.sv
// Single push-button gesture decoder: short click -> START/STOP, long hold -> RESET.
// Optional macro BTN_MIN_CLICK_EN suppresses START/STOP for clicks shorter than MIN_CLICK_MS.
module btn_gesture_decoder #(
  parameter int F_CLK_HZ       = 25_000_000,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int DB_MS          = 5,
  parameter int LONG_PRESS_MS  = 1000,
  parameter int MIN_CLICK_MS   = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic running,
  output logic start_pulse,
  output logic stop_pulse,
  output logic reset_pulse,
  output logic btn_level,
  output logic long_active
);

  localparam int DB_CYC   = (F_CLK_HZ / 1000) * DB_MS;
  localparam int LONG_CYC = (F_CLK_HZ / 1000) * LONG_PRESS_MS;
  localparam int DB_W     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int HOLD_W   = $clog2(LONG_CYC + 1);

  typedef enum logic [1:0] {REL, PRS, LNG} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_db;
  logic              r_db_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_start;
  logic              r_stop;
  logic              r_reset;
  logic              r_long;
  logic              w_norm;
  logic              w_rise;
  logic              w_fall;
  logic              w_click_ok;
  logic              w_start_nxt;
  logic              w_stop_nxt;
  logic              w_reset_nxt;
  logic              w_long_nxt;

  assign w_norm = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Synchroniser, debounce and edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DB_CYC - 1)) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_rise = r_db & ~r_db_d;
  assign w_fall = ~r_db & r_db_d;

  // Hold timer measures time spent in PRS since the debounced press edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_rise) begin
      r_hold <= '0;
    end else if ((r_state == PRS) && (r_hold != HOLD_W'(LONG_CYC))) begin
      r_hold <= r_hold + 1'b1;
    end
  end

`ifdef BTN_MIN_CLICK_EN
  localparam int MIN_CYC = (F_CLK_HZ / 1000) * MIN_CLICK_MS;
  assign w_click_ok = (r_hold >= HOLD_W'(MIN_CYC - 1));
`else
  assign w_click_ok = 1'b1;
`endif

  // Release is tested before the long-press threshold so a same-cycle release is a click
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_stop_nxt  = 1'b0;
    w_reset_nxt = 1'b0;
    case (r_state)
      REL: begin
        if (w_rise) w_state_nxt = PRS;
      end
      PRS: begin
        if (w_fall) begin
          w_state_nxt = REL;
          if (w_click_ok) begin
            w_start_nxt = ~running;
            w_stop_nxt  = running;
          end
        end else if (r_hold == HOLD_W'(LONG_CYC - 1)) begin
          w_state_nxt = LNG;
          w_reset_nxt = 1'b1;
        end
      end
      LNG: begin
        if (w_fall) w_state_nxt = REL;
      end
      default: w_state_nxt = REL;
    endcase
    w_long_nxt = (w_state_nxt == LNG);
  end

  // FSM state and registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= REL;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_reset <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= w_start_nxt;
      r_stop  <= w_stop_nxt;
      r_reset <= w_reset_nxt;
      r_long  <= w_long_nxt;
    end
  end

  assign start_pulse = r_start;
  assign stop_pulse  = r_stop;
  assign reset_pulse = r_reset;
  assign btn_level   = r_db;
  assign long_active = r_long;

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Self-checking bench for btn_gesture_decoder: duration-based press model plus directed scenarios.
module tb_btn_gesture_decoder;

  localparam int F_CLK_HZ       = 1000;
  localparam int DB_MS          = 5;
  localparam int LONG_PRESS_MS  = 100;
  localparam int MIN_CLICK_MS   = 20;
  localparam int BTN_ACTIVE_LOW = 1;
  localparam int DB_CYC         = 5;
  localparam int LONG_CYC       = 100;
  localparam int MIN_CYC        = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b1;
  logic running = 1'b0;
  logic start_pulse, stop_pulse, reset_pulse, btn_level, long_active;

  btn_gesture_decoder #(
    .F_CLK_HZ(F_CLK_HZ), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW), .DB_MS(DB_MS),
    .LONG_PRESS_MS(LONG_PRESS_MS), .MIN_CLICK_MS(MIN_CLICK_MS)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .running(running),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .reset_pulse(reset_pulse),
    .btn_level(btn_level), .long_active(long_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit click_long_enough(input int d);
`ifdef BTN_MIN_CLICK_EN
    return d >= MIN_CYC;
`else
    return 1'b1;
`endif
  endfunction

  // Model: debounced level follows the sync'd pin once DB_CYC consecutive samples disagree;
  // a press of D debounced cycles is a click if D <= LONG_CYC, otherwise RESET at LONG_CYC+1.
  int n = 0;
  bit m_lvl, m_dl0, m_dl1, m_in_press, m_fall_pend, m_long;
  bit m_start, m_stop, m_reset;
  int m_r, m_f;
  bit win[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lvl = 0; m_dl0 = 0; m_dl1 = 0; m_in_press = 0; m_fall_pend = 0; m_long = 0;
      m_start = 0; m_stop = 0; m_reset = 0;
      win.delete();
    end else begin
      bit s2, prev, all_diff;
      n++;
      s2 = m_dl1;
      m_dl1 = m_dl0;
      m_dl0 = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
      win.push_back(s2);
      if (win.size() > DB_CYC) void'(win.pop_front());
      prev = m_lvl;
      all_diff = (win.size() == DB_CYC);
      foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
      if (all_diff) begin
        m_lvl = ~m_lvl;
        win.delete();
      end
      m_start = 0; m_stop = 0; m_reset = 0;
      if (m_fall_pend) begin
        m_fall_pend = 0;
        if ((m_f - m_r) <= LONG_CYC && click_long_enough(m_f - m_r)) begin
          m_start = !running;
          m_stop  = running;
        end
        m_in_press = 0;
        m_long = 0;
      end
      if (m_in_press && n == m_r + LONG_CYC + 1) begin
        m_reset = 1;
        m_long = 1;
      end
      if (!prev && m_lvl) begin m_in_press = 1; m_r = n; end
      if (prev && !m_lvl && m_in_press) begin m_fall_pend = 1; m_f = n; end
    end
  end

  // Per-cycle comparison against the model, plus event counters for directed checks
  int c_start, c_stop, c_reset, c_lvl, c_long, t_start, t_stop, t_reset;

  always @(negedge clk) begin
    chk("outputs_vs_model",
        int'({start_pulse, stop_pulse, reset_pulse, btn_level, long_active}),
        int'({m_start, m_stop, m_reset, m_lvl, m_long}));
    chk("pulses_exclusive", int'($onehot0({start_pulse, stop_pulse, reset_pulse})), 1);
    if (start_pulse) begin c_start++; t_start = n; end
    if (stop_pulse)  begin c_stop++;  t_stop  = n; end
    if (reset_pulse) begin c_reset++; t_reset = n; end
    if (btn_level)   c_lvl++;
    if (long_active) c_long++;
  end

  task automatic tick(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic clear_counts();
    c_start = 0; c_stop = 0; c_reset = 0; c_lvl = 0; c_long = 0;
    t_start = -1; t_stop = -1; t_reset = -1;
  endtask

  int t_press, t_rel, t_rst;

  task automatic press(input int len, input int idle);
    clear_counts();
    btn_raw = 1'b0; t_press = n;
    tick(len);
    btn_raw = 1'b1; t_rel = n;
    tick(idle);
  endtask

  initial begin
    tick(3);
    chk("reset_outputs_zero",
        int'({start_pulse, stop_pulse, reset_pulse, btn_level, long_active}), 0);
    rst = 1'b0;
    tick(10);

    // Short click while idle -> START
    running = 1'b0;
    press(40, 30);
    chk("s1_start_count", c_start, 1);
    chk("s1_stop_count", c_stop, 0);
    chk("s1_reset_count", c_reset, 0);
    chk("s1_start_latency", t_start - t_rel, 8);
    chk("s1_level_cycles", c_lvl, 40);

    // Short click while running -> STOP
    running = 1'b1;
    press(40, 30);
    chk("s2_stop_count", c_stop, 1);
    chk("s2_start_count", c_start, 0);
    chk("s2_stop_latency", t_stop - t_rel, 8);

    // Long hold -> RESET while still held, no click on release
    running = 1'b0;
    press(200, 30);
    chk("s3_reset_count", c_reset, 1);
    chk("s3_reset_latency", t_reset - t_press, 108);
    chk("s3_click_count", c_start + c_stop, 0);
    chk("s3_long_cycles", c_long, 100);

    // Short glitches never pass the debouncer
    clear_counts();
    repeat (10) begin
      btn_raw = 1'b0; tick(3);
      btn_raw = 1'b1; tick(3);
    end
    tick(20);
    chk("s4_level_cycles", c_lvl, 0);
    chk("s4_pulse_count", c_start + c_stop + c_reset, 0);

    // Very short debounced click
    press(10, 30);
`ifdef BTN_MIN_CLICK_EN
    chk("s5_start_count", c_start, 0);
`else
    chk("s5_start_count", c_start, 1);
`endif
    chk("s5_reset_count", c_reset, 0);

    // Release exactly at the long-press threshold is still a click
    press(100, 30);
    chk("b100_start_count", c_start, 1);
    chk("b100_reset_count", c_reset, 0);
    press(101, 30);
    chk("b101_reset_count", c_reset, 1);
    chk("b101_start_count", c_start, 0);

    // running changes mid-press; value at release decides
    clear_counts();
    running = 1'b1;
    btn_raw = 1'b0; tick(20);
    running = 1'b0; tick(20);
    btn_raw = 1'b1; tick(30);
    chk("s7_start_count", c_start, 1);
    chk("s7_stop_count", c_stop, 0);

    // Reset mid-press, then the held button is re-debounced as a fresh press
    clear_counts();
    btn_raw = 1'b0; tick(50);
    rst = 1'b1; #1;
    chk("s6_outputs_cleared",
        int'({start_pulse, stop_pulse, reset_pulse, btn_level, long_active}), 0);
    tick(2);
    rst = 1'b0; t_rst = n;
    tick(148);
    btn_raw = 1'b1; tick(30);
    chk("s6_reset_count", c_reset, 1);
    chk("s6_reset_latency", t_reset - t_rst, 108);
    chk("s6_click_count", c_start + c_stop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
